// File: rtl/alu_issue_ctrl.sv
// Sequential issue/capture front end for the 8-bit combinational ALU.
// Registers one command onto the ALU, waits SETTLE cycles, and returns the result over valid/ready.
module alu_issue_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_cin,
  input  logic             cmd_chain,
  input  logic             carry_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_cout,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_d,
  output logic             rsp_cout,
  output logic             rsp_z,
  output logic             carry_q,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       capture;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign capture   = (state == ST_SETTLE) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      alu_cin  <= 1'b0;
      rsp_d    <= '0;
      rsp_cout <= 1'b0;
      rsp_z    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            // carry_q here is the pre-edge value, so a same-edge carry_clr does not affect the chain
            alu_cin <= cmd_chain ? carry_q : cmd_cin;
            cnt     <= SETTLE_INIT;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_d    <= alu_d;
            rsp_cout <= alu_cout;
            rsp_z    <= alu_z;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture has priority over an explicit clear on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         carry_q <= 1'b0;
    else if (capture)   carry_q <= alu_cout;
    else if (carry_clr) carry_q <= 1'b0;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front end for the team's 8-bit combinational ALU; sits directly upstream and drives the ALU operand, select and carry-in inputs.
- Captures the ALU's result, carry-out and zero outputs, and returns them over a valid/ready response port.
- Holds a carry flag between operations, so multi-byte arithmetic can chain carry-out into the next carry-in.
- One command in flight at a time; configurable settle delay between driving the ALU and sampling it.

Parameters:
WIDTH, 8, operand/result width
SEL_W, 4, ALU select width
SETTLE, 1, clock cycles the ALU inputs are held stable before the result is sampled; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block accepts a command
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
cmd_sel  input  SEL_W  ALU select code, passed through unmodified
cmd_cin  input  1  explicit carry-in
cmd_chain  input  1  1 = use stored carry_q as carry-in, ignore cmd_cin
carry_clr  input  1  synchronous clear of carry_q
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_sel  output  SEL_W  registered select to ALU
alu_cin  output  1  registered carry-in to ALU
alu_d  input  WIDTH  ALU result
alu_cout  input  1  ALU carry-out
alu_z  input  1  ALU zero flag
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_d  output  WIDTH  captured result
rsp_cout  output  1  captured carry-out
rsp_z  output  1  captured zero flag
carry_q  output  1  stored carry flag
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all alu_* = 0; all rsp_* = 0; rsp_valid=0; carry_q=0; settle counter=0.
  - Reset mid-operation abandons the command; no response is produced.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1 (decoded from state only, no combinational path from cmd_valid).
  - Edge with cmd_valid=1: latch alu_a=cmd_a, alu_b=cmd_b, alu_sel=cmd_sel.
  - alu_cin = cmd_chain ? carry_q : cmd_cin.
  - Load counter=SETTLE-1; go to SETTLE.
- SETTLE:
  - cmd_ready=0; alu_* held stable.
  - Counter>0: decrement.
  - Counter==0 at an edge: rsp_d=alu_d, rsp_cout=alu_cout, rsp_z=alu_z; carry_q=alu_cout; rsp_valid=1; go to RESP.
- RESP:
  - rsp_valid=1; rsp_* stable.
  - Edge with rsp_ready=1: rsp_valid=0; go to IDLE.
  - rsp_* and alu_* keep their last values until overwritten.
- Latency:
  - Command accepted at edge k; ALU inputs valid from edge k.
  - ALU sampled at edge k+SETTLE; rsp_valid high from edge k+SETTLE.
  - With rsp_ready held high, cmd_ready returns at edge k+SETTLE+1.
  - Minimum command period: SETTLE+2 cycles.
- No new command is accepted in the same cycle as the response handshake.
- carry_clr:
  - Clears carry_q at the next edge in any state.
  - Capture and carry_clr on the same edge: capture wins (carry_q=alu_cout).
  - Accept with cmd_chain=1 and carry_clr=1 on the same edge: alu_cin takes the old carry_q.
- cmd_valid in SETTLE or RESP is ignored; the command is not latched.
- rsp_ready in IDLE or SETTLE has no effect.
- cmd_sel is opaque to this block; all ALU semantics stay in the ALU.

Test Plan:
The bench uses an ALU stub: D=(A+B+Cin) mod 256, C_out=carry, z=(D==0). SETTLE=1 unless stated.
1. Basic add: A=81, B=80, sel=0000, cin=1, chain=0 -> alu_* valid the cycle after accept; rsp_valid one edge later; rsp_d=162, rsp_cout=0, rsp_z=0; cmd_ready back after the rsp_ready handshake.
2. Carry chain: cmd (200,100,cin=0) -> rsp_d=44, rsp_cout=1, carry_q=1; then cmd (1,2,chain=1, cmd_cin=0) -> alu_cin=1, rsp_d=4, carry_q=0.
3. Zero flag and backpressure: (255,0,cin=1) -> rsp_d=0, rsp_cout=1, rsp_z=1. Hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, a new cmd_valid is ignored. Release -> IDLE.
4. SETTLE=3: accept at edge k -> ALU sampled at edge k+3. Bench changes the stub output mid-settle -> only the value present at edge k+3 is captured.
5. Reset mid-SETTLE: assert rst_n=0 between clock edges -> immediately all outputs 0, carry_q=0, state IDLE, no rsp_valid pulse after release.
6. carry_clr coinciding with capture of cout=1 -> carry_q=1. carry_clr alone in IDLE -> carry_q=0 next edge.
